// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_FINISH,
        ST_ERR
    } state_t;

    // Stream framing: big-endian word count, then big-endian instruction bytes
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    // True when the requested word count does not fit in the memory
    function automatic logic len_exceeds(input logic [15:0] len, input int unsigned depth);
        return {16'd0, len} > depth;
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles big-endian stream bytes into one instruction word.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              last_byte
);

    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    // Next word/count: clear at the start of a payload, shift in on each accepted byte
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = {word_q[WORD_W-9:0], byte_in};
            cnt_d  = cnt_q + BYTE_CNT_W'(1);
        end
    end

    // Shift register and byte counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word      = word_q;
    assign last_byte = (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into
// instruction memory, holding the core in reset until the image is complete.
// Handshake: a byte transfers on a rising clk edge when rx_valid && rx_ready;
// rx_ready depends only on the state register, never on rx_valid.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int          LEN_W = 8 * HDR_BYTES;
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [LEN_W-1:0]      words_left_q, words_left_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cpu_reset_q, cpu_reset_d;

    logic                  accept;
    logic [LEN_W-1:0]      len_full;
    logic [WORD_W-1:0]     word;
    logic                  last_byte;
    logic                  shift_en;
    logic                  clear;

    assign rx_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA);
    assign accept   = rx_valid && rx_ready;
    assign len_full = {len_hi_q, rx_data};
    assign shift_en = accept && (state_q == ST_DATA);
    assign clear    = accept && (state_q == ST_LEN_LO);

    word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .clear     (clear),
        .byte_in   (rx_data),
        .word      (word),
        .last_byte (last_byte)
    );

    // Next-state logic for the session FSM and its bookkeeping registers
    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        cpu_reset_d  = cpu_reset_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LEN_HI;
                    cpu_reset_d = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_full == '0) begin
                        state_d = ST_FINISH;
                    end else if (len_exceeds(len_full, DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d      = ST_DATA;
                        addr_d       = '0;
                        words_left_d = len_full;
                    end
                end
            end
            ST_DATA: begin
                if (accept && last_byte) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d       = addr_q + ADDR_WIDTH'(1);
                words_left_d = words_left_q - LEN_W'(1);
                state_d      = (words_left_q == LEN_W'(1)) ? ST_FINISH : ST_DATA;
            end
            ST_FINISH: begin
                // Core leaves reset on the edge that ends this cycle
                cpu_reset_d = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_ERR: begin
                if (start) begin
                    state_d     = ST_LEN_HI;
                    cpu_reset_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cpu_reset_d = 1'b1;
            end
        endcase
    end

    // State and bookkeeping registers; reset aborts any session and holds the core
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_hi_q     <= '0;
            words_left_q <= '0;
            addr_q       <= '0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    assign imem_we    = (state_q == ST_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = word;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign done       = (state_q == ST_FINISH);
    assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: per-cycle vector table plus directed multi-cycle sequences.
module tb_imem_loader;

    localparam int AW = 4;
    localparam int W  = AW + 32;

    // Expected flag vector order: {rx_ready, imem_we, cpu_reset, busy, done, error}
    localparam logic [5:0] F_HDR  = 6'b101100;
    localparam logic [5:0] F_WR   = 6'b011100;
    localparam logic [5:0] F_FIN  = 6'b001110;
    localparam logic [5:0] F_OFF  = 6'b000000;
    localparam logic [5:0] F_ERR  = 6'b001001;
    localparam logic [5:0] F_RST  = 6'b001000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: write log, done pulses, cpu_reset drops while watched
    logic [W-1:0] wr_log[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int cpu_low_cnt = 0;
    logic watch_cpu = 1'b0;

    always @(negedge clk) begin
        if (imem_we) wr_log.push_back({imem_addr, imem_wdata});
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (watch_cpu && !cpu_reset) cpu_low_cnt = cpu_low_cnt + 1;
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int wr_base;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {rx_ready, imem_we, cpu_reset, busy, done, error};
    endfunction

    task automatic check_writes(input string name);
        int n;
        n = wr_log.size() - wr_base;
        check({name, "_count"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            check({name, "_entry"}, 64'(wr_log[wr_base + i]), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
    endtask

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wr_base = wr_log.size();
        exp_q.delete();
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1; rx_valid = 1'b0;
        t0 = cyc;
        @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b1; rx_data = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_timeout", 64'(n), 64'(0));
        else @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; rx_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            start = 1'b0; rx_valid = 1'b0;
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 64'(n), 64'(0));
    endtask

    // Per-cycle vector table
    typedef struct {
        logic          start;
        logic          valid;
        logic [7:0]    data;
        logic [5:0]    flags;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic s, input logic v, input logic [7:0] d,
                                    input logic [5:0] f, input logic [AW-1:0] a = '0,
                                    input logic [31:0] w = '0);
        vec_t e;
        e.start = s; e.valid = v; e.data = d; e.flags = f; e.addr = a; e.wdata = w;
        vecs.push_back(e);
    endfunction

    initial begin
        int t0;
        int d0;

        // Two-word load, valid held high: FINISH lands 13 cycles after the start cycle
        add_vec(1, 0, 8'h00, F_HDR);
        add_vec(0, 1, 8'h00, F_HDR);
        add_vec(0, 1, 8'h02, F_HDR);
        add_vec(0, 1, 8'h20, F_HDR);
        add_vec(0, 1, 8'h08, F_HDR);
        add_vec(0, 1, 8'h00, F_HDR);
        add_vec(0, 1, 8'h02, F_WR, 4'd0, 32'h2008_0002);
        add_vec(0, 1, 8'h20, F_HDR);
        add_vec(0, 1, 8'h20, F_HDR);
        add_vec(0, 1, 8'h0A, F_HDR);
        add_vec(0, 1, 8'h00, F_HDR);
        add_vec(0, 1, 8'h01, F_WR, 4'd1, 32'h200A_0001);
        add_vec(0, 0, 8'h00, F_FIN);
        add_vec(0, 0, 8'h00, F_OFF);
        // Zero-length image: done 3 cycles after start
        add_vec(1, 0, 8'h00, F_HDR);
        add_vec(0, 1, 8'h00, F_HDR);
        add_vec(0, 1, 8'h00, F_FIN);
        add_vec(0, 0, 8'h00, F_OFF);
        // Oversize count 17, then 256, then recovery with a one-word load
        add_vec(1, 0, 8'h00, F_HDR);
        add_vec(0, 1, 8'h00, F_HDR);
        add_vec(0, 1, 8'h11, F_ERR);
        add_vec(0, 1, 8'h55, F_ERR);
        add_vec(1, 0, 8'h00, F_HDR);
        add_vec(0, 1, 8'h01, F_HDR);
        add_vec(0, 1, 8'h00, F_ERR);
        add_vec(1, 0, 8'h00, F_HDR);
        add_vec(0, 1, 8'h00, F_HDR);
        add_vec(0, 1, 8'h01, F_HDR);
        add_vec(0, 1, 8'h3C, F_HDR);
        add_vec(0, 1, 8'h01, F_HDR);
        add_vec(0, 1, 8'h12, F_HDR);
        add_vec(0, 1, 8'h34, F_WR, 4'd0, 32'h3C01_1234);
        add_vec(0, 0, 8'h00, F_FIN);
        add_vec(0, 0, 8'h00, F_OFF);
        // Count equal to depth (16) is accepted
        add_vec(1, 0, 8'h00, F_HDR);
        add_vec(0, 1, 8'h00, F_HDR);
        add_vec(0, 1, 8'h10, F_HDR);
        add_vec(0, 0, 8'h00, F_HDR);

        // Reset state
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", 64'(flags()), 64'(F_RST));
        check("reset_addr", 64'(imem_addr), 64'(0));
        check("reset_wdata", 64'(imem_wdata), 64'(0));
        reset = 1'b0;
        wr_base = wr_log.size();

        // Table replay
        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].start; rx_valid = vecs[i].valid; rx_data = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vecs[i].flags));
            if (vecs[i].flags[4]) begin
                check($sformatf("vec%0d_addr", i), 64'(imem_addr), 64'(vecs[i].addr));
                check($sformatf("vec%0d_wdata", i), 64'(imem_wdata), 64'(vecs[i].wdata));
            end
        end

        // Stall of 3 cycles after byte 2 of word 0: same writes, done 3 cycles later
        do_reset();
        d0 = done_cnt;
        pulse_start(t0);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08);
        gap(3);
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h200A_0001);
        exp_q.push_back({4'd0, 32'h2008_0002});
        exp_q.push_back({4'd1, 32'h200A_0001});
        wait_done(20);
        check("stall_done_cycle", 64'(done_cyc - t0), 64'(16));
        check("stall_done_count", 64'(done_cnt - d0), 64'(1));
        check_writes("stall_wr");

        // Reset after 2 of 4 words, with start held during reset
        do_reset();
        pulse_start(t0);
        send_byte(8'h00); send_byte(8'h04);
        send_word(32'hAABB_CCDD);
        send_word(32'h0123_4567);
        send_byte(8'h55); send_byte(8'h66);
        exp_q.push_back({4'd0, 32'hAABB_CCDD});
        exp_q.push_back({4'd1, 32'h0123_4567});
        @(negedge clk);
        reset = 1'b1; start = 1'b1; rx_valid = 1'b1;
        #1;
        check("abort_async_flags", 64'(flags()), 64'(F_RST));
        @(posedge clk);
        #1;
        check("abort_flags", 64'(flags()), 64'(F_RST));
        check("abort_addr", 64'(imem_addr), 64'(0));
        check("abort_wdata", 64'(imem_wdata), 64'(0));
        @(negedge clk);
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("start_vs_reset_flags", 64'(flags()), 64'(F_RST));
        gap(3);
        check_writes("abort_wr");

        // start during DATA is ignored; then a reload rewrites address 0
        do_reset();
        d0 = done_cnt;
        pulse_start(t0);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08);
        @(negedge clk);
        start = 1'b1; rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_start_busy", 64'(flags()), 64'(F_HDR));
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h200A_0001);
        exp_q.push_back({4'd0, 32'h2008_0002});
        exp_q.push_back({4'd1, 32'h200A_0001});
        wait_done(20);
        check("mid_start_done_cycle", 64'(done_cyc - t0), 64'(14));
        check("mid_start_done_count", 64'(done_cnt - d0), 64'(1));
        check_writes("mid_start_wr");
        gap(2);
        check("loaded_cpu_reset", 64'(cpu_reset), 64'(0));

        wr_base = wr_log.size();
        d0 = cpu_low_cnt;
        pulse_start(t0);
        #1;
        check("reload_cpu_reset", 64'(cpu_reset), 64'(1));
        watch_cpu = 1'b1;
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h0800_0008);
        exp_q.push_back({4'd0, 32'h0800_0008});
        wait_done(20);
        watch_cpu = 1'b0;
        check("reload_done_cycle", 64'(done_cyc - t0), 64'(8));
        check("reload_cpu_low", 64'(cpu_low_cnt - d0), 64'(0));
        check_writes("reload_wr");
        gap(1);
        check("reload_cpu_release", 64'(cpu_reset), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
